// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   tx_state_e      : shifter FSM encoding
//   *_ADDR_DEF      : default decode addresses
//   ST_*            : bit positions inside the status word
//   status_word()   : packs the status flags into the 32-bit read value
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TX_ADDR_DEF     = 32'h1001_0024;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h1001_0028;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  // WriteData bit that clears the sticky overflow flag on a status store
  localparam int OVF_CLR_BIT = 2;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic busy);
    logic [31:0] w;
    w            = '0;
    w[ST_OVF]    = ovf;
    w[ST_FULL]   = full;
    w[ST_EMPTY]  = empty;
    w[ST_BUSY]   = busy;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
//   clk, reset : clock, async active-high reset
//   push, din  : write request / data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever !empty
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop on the same edge frees a slot, so a full FIFO still takes the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;   // DEPTH is a power of 2: wraps naturally
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the processor data bus.
//   clk, reset        : clock, async active-high reset
//   Address/WriteData : processor byte address / store data
//   MemWrite/MemRead  : store / load strobes
//   ReadData          : status word on a load from STATUS_ADDR, else 0
//   Hit               : Address decodes to this block
//   TxSerial          : serial line (idle high, registered)
//   TxBusy            : shifter is mid-frame
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxSerial,
  output logic        TxBusy
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic        tx_hit, st_hit, push_req, ovf_set, ovf_clr;
  logic        pop, baud_end;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        unused_wdata;

  assign tx_hit   = (Address == TX_ADDR);
  assign st_hit   = (Address == STATUS_ADDR);
  assign Hit      = tx_hit || st_hit;
  assign push_req = MemWrite && tx_hit;
  assign ovf_clr  = MemWrite && st_hit && WriteData[OVF_CLR_BIT];
  // Dropped only when full and the shifter is not popping on this same edge.
  assign ovf_set  = push_req && fifo_full && !pop;
  assign unused_wdata = ^{WriteData[31:8], WriteData[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign TxSerial = tx_q;
  assign TxBusy   = (state_q != IDLE);
  assign ReadData = (MemRead && st_hit) ?
                    status_word(ovf_q, fifo_full, fifo_empty, TxBusy) : 32'h0;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;    // set wins over a same-edge clear
  end

  // tx_d is the line level for the next cycle, so each transition loads the
  // level of the bit being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // chain straight into the next frame, no idle cycle
            pop     = 1'b1;
            shift_d = fifo_dout;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int          CPB = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;

  logic        clk, reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemWrite, MemRead, Hit, TxSerial, TxBusy;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .TxSerial  (TxSerial),
    .TxBusy    (TxBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address = addr; WriteData = data; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; Address = '0; WriteData = '0;
  endtask

  // Combinational status read inside the current cycle.
  task automatic lw_check(input string name, input logic [31:0] exp);
    Address = STA; MemRead = 1'b1;
    #1;
    check(name, ReadData, exp);
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || TxBusy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // Serial monitor: samples each bit mid-period and scores against exp_q.
  initial begin
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge clk);
      if (!reset && TxSerial == 1'b0) begin
        ab = 1'b0;
        b  = '0;
        starts.push_back(cyc);
        mon_wait(CPB + CPB/2, ab);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            b[i] = TxSerial;
            mon_wait(CPB, ab);
          end
        end
        if (!ab) begin
          check("stop_bit", 32'(TxSerial), 32'd1);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got 0x%02h want no frame", b);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (b !== e) begin
              bad++;
              $display("FAIL frame_data: got 0x%02h want 0x%02h", b, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   busy_n;

  initial begin
    Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_tx", 32'(TxSerial), 32'd1);
    check("rst_busy", 32'(TxBusy), 32'd0);
    lw_check("rst_status", 32'h2);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Address decode / read-mux vectors while idle and empty.
    vecs[0] = '{"st_read",    STA,           32'h0,  1'b0, 1'b1, 32'h2, 1'b1};
    vecs[1] = '{"tx_read",    TXA,           32'h0,  1'b0, 1'b1, 32'h0, 1'b1};
    vecs[2] = '{"st_noread",  STA,           32'h0,  1'b0, 1'b0, 32'h0, 1'b1};
    vecs[3] = '{"other_wr",   32'h1001_0020, 32'hFF, 1'b1, 1'b1, 32'h0, 1'b0};
    vecs[4] = '{"near_miss",  32'h1001_0025, 32'h0,  1'b0, 1'b1, 32'h0, 1'b0};
    vecs[5] = '{"st_after",   STA,           32'h0,  1'b0, 1'b1, 32'h2, 1'b1};
    foreach (vecs[i]) begin
      @(negedge clk);
      Address = vecs[i].addr; WriteData = vecs[i].wdata;
      MemWrite = vecs[i].we; MemRead = vecs[i].re;
      #1;
      check({vecs[i].name, "_rd"}, ReadData, vecs[i].exp_rd);
      check({vecs[i].name, "_hit"}, 32'(Hit), 32'(vecs[i].exp_hit));
      @(posedge clk);
      #1;
      MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
    end
    check("idle_line", 32'(TxSerial), 32'd1);

    // 1: single byte, busy for exactly one frame
    exp_q.push_back(8'h55);
    sw(TXA, 32'h55);
    check("t1_tx_at_e0", 32'(TxSerial), 32'd1);
    busy_n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (TxBusy) busy_n++;
      else if (busy_n > 0) break;
    end
    check("t1_busy_cycles", 32'(busy_n), 32'(10 * CPB));
    drain("t1");

    // 2: five consecutive stores while idle, all accepted, back-to-back frames
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      sw(TXA, 32'(i));
      if (i == 1) check("t2_tx_e0", 32'(TxSerial), 32'd1);
      if (i == 2) check("t2_tx_e1", 32'(TxSerial), 32'd0);
    end
    lw_check("t2_status", 32'h5);
    drain("t2");
    check("t2_frames", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++)
      check("t2_gap", 32'(starts[i] - starts[i-1]), 32'(10 * CPB));

    // 3: burst of six while a prior frame is in flight
    exp_q.push_back(8'hA0);
    sw(TXA, 32'hA0);
    repeat (2) @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back(8'hB0 + 8'(i));
      sw(TXA, 32'hB0 + 32'(i));
    end
    lw_check("t3_status", 32'hD);
    drain("t3");
    lw_check("t3_idle_ovf", 32'hA);

    // 4: overflow clear needs WriteData[2]
    sw(STA, 32'h3);
    lw_check("t4_noclr", 32'hA);
    sw(STA, 32'h4);
    lw_check("t4_clr", 32'h2);

    // 5: async reset mid-frame
    sw(TXA, 32'h3C);
    sw(TXA, 32'hC3);
    repeat (12) @(posedge clk);
    #1;
    lw_check("t5_pre", 32'h1);
    Address = STA; MemRead = 1'b1;
    reset = 1'b1;
    #1;
    check("t5_tx", 32'(TxSerial), 32'd1);
    check("t5_busy", 32'(TxBusy), 32'd0);
    check("t5_status", ReadData, 32'h2);
    MemRead = 1'b0; Address = '0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_after_tx", 32'(TxSerial), 32'd1);

    // 6: store to a full FIFO on the STOP-end pop edge is accepted
    exp_q.push_back(8'h11);
    sw(TXA, 32'h11);                      // E0, popped at E1
    for (int i = 1; i <= 4; i++) begin    // E1..E4 -> full
      exp_q.push_back(8'h20 + 8'(i));
      sw(TXA, 32'h20 + 32'(i));
    end
    lw_check("t6_full", 32'h5);
    repeat (36) @(posedge clk);           // now at E40
    exp_q.push_back(8'h99);
    sw(TXA, 32'h99);                      // lands on E41, the STOP-end edge
    lw_check("t6_status", 32'h5);
    drain("t6");
    lw_check("t6_final", 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
